// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for a small control processor.
// Walks the instruction memory address, takes absolute branches, and calls
// and returns from subroutines. Call targets come from a 16-entry table and
// return addresses go on a bounded return stack. Overflow and underflow of
// that stack park the sequencer in FAULT. Finishing a program parks it in
// HALT. Only start or reset brings it out of either state.
module fetch_sequencer #(
    parameter int AW        = 10,
    parameter int SDEPTH    = 4,
    parameter int SUB0_ADDR = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] prog_base,
    input  logic          stall,
    input  logic          br_nz,
    input  logic [7:0]    br_target,
    input  logic          jsr,
    input  logic [3:0]    jsr_idx,
    input  logic          rfsr,
    input  logic          done,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted,
    output logic          fault,
    output logic [2:0]    depth
);

    // Width of a return-stack slot index. The depth counter itself is 3 bits,
    // so the stack may hold at most 7 entries.
    localparam int SW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [2:0] DEPTH_FULL = 3'(SDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [2:0]    depth_q, depth_d;
    logic [AW-1:0] stack_q [SDEPTH];
    logic [AW-1:0] tbl_q [16];

    logic          pushEn;
    logic          clearStack;
    logic [SW-1:0] pushIdx;
    logic [SW-1:0] topIdx;
    logic [AW-1:0] retAddr;

    // The next free slot sits at index depth. The top of the stack sits one below it.
    // Both are only used when the matching bound check has passed.
    assign pushIdx = SW'(depth_q);
    assign topIdx  = SW'(depth_q - 3'd1);
    assign retAddr = pc_q + AW'(1);

    // Control state, program counter and stack depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // Next-state decode. start overrides everything in every state.
    // Otherwise only an unstalled RUN cycle looks at the decoded controls,
    // in the order done, rfsr, jsr, br_nz. A call that would overflow the stack
    // or a return with nothing to return to freezes pc and the stack in FAULT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        depth_d    = depth_q;
        pushEn     = 1'b0;
        clearStack = 1'b0;
        if (start) begin
            state_d    = RUN;
            pc_d       = prog_base;
            depth_d    = '0;
            clearStack = 1'b1;
        end else if (state_q == RUN && !stall) begin
            if (done) begin
                state_d = HALT;
            end else if (rfsr) begin
                if (depth_q == 3'd0) begin
                    state_d = FAULT;
                end else begin
                    pc_d    = stack_q[topIdx];
                    depth_d = depth_q - 3'd1;
                end
            end else if (jsr) begin
                if (depth_q == DEPTH_FULL) begin
                    state_d = FAULT;
                end else begin
                    pushEn  = 1'b1;
                    pc_d    = tbl_q[jsr_idx];
                    depth_d = depth_q + 3'd1;
                end
            end else if (br_nz) begin
                pc_d = AW'(br_target);
            end else begin
                pc_d = pc_q + AW'(1);
            end
        end
    end

    // Return stack storage. A fresh start wipes it so that nothing stale
    // from an earlier program can be returned to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SDEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (clearStack) begin
            for (int i = 0; i < SDEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (pushEn) begin
            stack_q[pushIdx] <= retAddr;
        end
    end

    // Subroutine table. It can be written in any state. A jsr in the same cycle
    // as a write reads the old contents, because the lookup above uses the
    // registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                tbl_q[i] <= (i == 0) ? AW'(SUB0_ADDR) : '0;
            end
        end else if (cfg_we) begin
            tbl_q[cfg_idx] <= cfg_addr;
        end
    end

    assign pc      = pc_q;
    assign depth   = depth_q;
    assign running = (state_q == RUN);
    assign halted  = (state_q == HALT);
    assign fault   = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each step drives one cycle of inputs,
// queues the expected pc/depth/flags and checks them just after the edge.
module tb_fetch_sequencer;

    localparam logic [2:0] F_IDLE  = 3'b000;
    localparam logic [2:0] F_RUN   = 3'b100;
    localparam logic [2:0] F_HALT  = 3'b010;
    localparam logic [2:0] F_FAULT = 3'b001;

    typedef struct {
        string      tag;
        logic [9:0] pc;
        logic [2:0] depth;
        logic [2:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] prog_base;
    logic       stall;
    logic       br_nz;
    logic [7:0] br_target;
    logic       jsr;
    logic [3:0] jsr_idx;
    logic       rfsr;
    logic       done;
    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic [9:0] cfg_addr;
    logic [9:0] pc;
    logic       running;
    logic       halted;
    logic       fault;
    logic [2:0] depth;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    fetch_sequencer #(.AW(10), .SDEPTH(4), .SUB0_ADDR(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_base (prog_base),
        .stall     (stall),
        .br_nz     (br_nz),
        .br_target (br_target),
        .jsr       (jsr),
        .jsr_idx   (jsr_idx),
        .rfsr      (rfsr),
        .done      (done),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .pc        (pc),
        .running   (running),
        .halted    (halted),
        .fault     (fault),
        .depth     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drop every one-cycle control back to its inactive value.
    task automatic clearControls();
        start     = 1'b0;
        prog_base = '0;
        stall     = 1'b0;
        br_nz     = 1'b0;
        br_target = '0;
        jsr       = 1'b0;
        jsr_idx   = '0;
        rfsr      = 1'b0;
        done      = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_addr  = '0;
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic checkOutput();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard: observed output with no expectation queued");
        end else begin
            e = expQ.pop_front();
            assert ({pc, depth, running, halted, fault} === {e.pc, e.depth, e.flags})
            else begin
                errors++;
                $error("[TB] FAIL %s: observed pc=%0d depth=%0d flags=%b, expected pc=%0d depth=%0d flags=%b",
                       e.tag, pc, depth, {running, halted, fault}, e.pc, e.depth, e.flags);
            end
        end
    endtask

    // Queue an expectation for outputs that must already hold, such as after an async reset.
    task automatic checkNow(input string tag, input logic [9:0] ePc,
                            input logic [2:0] eDepth, input logic [2:0] eFlags);
        exp_t e;
        e.tag = tag; e.pc = ePc; e.depth = eDepth; e.flags = eFlags;
        expQ.push_back(e);
        checkOutput();
    endtask

    // Clock in the inputs already driven by the caller, then check one edge later.
    task automatic applyStimulus(input string tag, input logic [9:0] ePc,
                                 input logic [2:0] eDepth, input logic [2:0] eFlags);
        exp_t e;
        e.tag = tag; e.pc = ePc; e.depth = eDepth; e.flags = eFlags;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        clearControls();
        checkOutput();
    endtask

    initial begin
        clearControls();
        rst_n = 1'b0;
        #3;
        checkNow("reset_state", 10'd0, 3'd0, F_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("idle_no_start", 10'd0, 3'd0, F_IDLE);

        // Plain sequential fetch from address 0.
        start = 1'b1; prog_base = 10'd0;
        applyStimulus("start_base0", 10'd0, 3'd0, F_RUN);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus("seq_from0", 10'(i), 3'd0, F_RUN);
        end

        // Call through table entry 0 and come back.
        start = 1'b1; prog_base = 10'd20;
        applyStimulus("start_base20", 10'd20, 3'd0, F_RUN);
        jsr = 1'b1; jsr_idx = 4'd0;
        applyStimulus("jsr_idx0", 10'd100, 3'd1, F_RUN);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus("seq_in_sub", 10'(100 + i), 3'd1, F_RUN);
        end
        rfsr = 1'b1;
        applyStimulus("rfsr_to_21", 10'd21, 3'd0, F_RUN);

        // Branch. Then a branch losing to a call. Then a table write racing a call.
        start = 1'b1; prog_base = 10'd84;
        applyStimulus("start_base84", 10'd84, 3'd0, F_RUN);
        br_nz = 1'b1; br_target = 8'd9;
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_addr = 10'd300;
        applyStimulus("br_to_9", 10'd9, 3'd0, F_RUN);
        br_nz = 1'b1; br_target = 8'd9; jsr = 1'b1; jsr_idx = 4'd3;
        applyStimulus("jsr_beats_br", 10'd300, 3'd1, F_RUN);
        jsr = 1'b1; jsr_idx = 4'd3;
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_addr = 10'd500;
        applyStimulus("jsr_sees_old_entry", 10'd300, 3'd2, F_RUN);
        jsr = 1'b1; jsr_idx = 4'd3;
        applyStimulus("jsr_sees_new_entry", 10'd500, 3'd3, F_RUN);
        rfsr = 1'b1;
        applyStimulus("rfsr_lvl3", 10'd301, 3'd2, F_RUN);
        rfsr = 1'b1;
        applyStimulus("rfsr_lvl2", 10'd301, 3'd1, F_RUN);
        rfsr = 1'b1;
        applyStimulus("rfsr_lvl1", 10'd10, 3'd0, F_RUN);

        // Nested calls until the stack overflows.
        start = 1'b1; prog_base = 10'd0;
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_addr = 10'd200;
        applyStimulus("start_for_ovf", 10'd0, 3'd0, F_RUN);
        for (int i = 1; i <= 4; i++) begin
            jsr = 1'b1; jsr_idx = 4'd1;
            applyStimulus("nested_jsr", 10'd200, 3'(i), F_RUN);
        end
        jsr = 1'b1; jsr_idx = 4'd1;
        applyStimulus("jsr_overflow", 10'd200, 3'd4, F_FAULT);
        rfsr = 1'b1;
        applyStimulus("fault_ignores_rfsr", 10'd200, 3'd4, F_FAULT);

        // Priority: rfsr over jsr, then done over rfsr.
        start = 1'b1; prog_base = 10'd50;
        applyStimulus("start_base50", 10'd50, 3'd0, F_RUN);
        jsr = 1'b1; jsr_idx = 4'd0;
        applyStimulus("jsr_from50", 10'd100, 3'd1, F_RUN);
        rfsr = 1'b1; jsr = 1'b1; jsr_idx = 4'd1;
        applyStimulus("rfsr_beats_jsr", 10'd51, 3'd0, F_RUN);
        done = 1'b1; rfsr = 1'b1;
        applyStimulus("done_beats_rfsr", 10'd51, 3'd0, F_HALT);

        // Return with an empty stack.
        start = 1'b1; prog_base = 10'd0;
        applyStimulus("start_for_unf", 10'd0, 3'd0, F_RUN);
        rfsr = 1'b1;
        applyStimulus("rfsr_underflow", 10'd0, 3'd0, F_FAULT);

        // done at 86, HALT holds, and start restarts.
        start = 1'b1; prog_base = 10'd86;
        applyStimulus("start_base86", 10'd86, 3'd0, F_RUN);
        done = 1'b1;
        applyStimulus("done_at_86", 10'd86, 3'd0, F_HALT);
        applyStimulus("halt_holds", 10'd86, 3'd0, F_HALT);
        start = 1'b1; prog_base = 10'd0;
        applyStimulus("restart_from_halt", 10'd0, 3'd0, F_RUN);

        // pc wraps at the top of memory. Stall freezes even a branch.
        start = 1'b1; prog_base = 10'd1023;
        applyStimulus("start_base1023", 10'd1023, 3'd0, F_RUN);
        applyStimulus("wrap_to_0", 10'd0, 3'd0, F_RUN);
        applyStimulus("after_wrap", 10'd1, 3'd0, F_RUN);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; br_nz = 1'b1; br_target = 8'd77;
            applyStimulus("stall_hold", 10'd1, 3'd0, F_RUN);
        end
        applyStimulus("stall_release", 10'd2, 3'd0, F_RUN);

        // Async reset in the middle of a subroutine discards the stack and the table.
        jsr = 1'b1; jsr_idx = 4'd0;
        applyStimulus("jsr_before_reset", 10'd100, 3'd1, F_RUN);
        #2;
        rst_n = 1'b0;
        #1;
        checkNow("async_reset_mid_sub", 10'd0, 3'd0, F_IDLE);
        #1;
        rst_n = 1'b1;
        start = 1'b1; prog_base = 10'd5;
        applyStimulus("start_after_reset", 10'd5, 3'd0, F_RUN);
        rfsr = 1'b1;
        applyStimulus("no_return_survives", 10'd5, 3'd0, F_FAULT);
        start = 1'b1; prog_base = 10'd7;
        applyStimulus("start_base7", 10'd7, 3'd0, F_RUN);
        jsr = 1'b1; jsr_idx = 4'd3;
        applyStimulus("entry3_reset_zero", 10'd0, 3'd1, F_RUN);
        applyStimulus("seq_after_entry3", 10'd1, 3'd1, F_RUN);

        if (expQ.size() != 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d leftover, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter AW, default 10, program-counter width; instruction memory depth is 2**AW words.
REQ-002 Parameter SDEPTH, default 4, return-stack depth in entries.
REQ-003 Parameter SUB0_ADDR, default 100, reset value of subroutine-table entry 0.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: start  in  1  one-cycle pulse; begins execution at prog_base.
REQ-008 Port: prog_base  in  AW  start address, sampled when start is accepted.
REQ-009 Port: stall  in  1  holds pc and state for the current cycle.
REQ-010 Port: br_nz  in  1  decoded bnzr whose tested register is nonzero.
REQ-011 Port: br_target  in  8  absolute branch target (z register), zero-extended to AW.
REQ-012 Port: jsr  in  1  decoded jtsr.
REQ-013 Port: jsr_idx  in  4  subroutine-table index from the jtsr operand.
REQ-014 Port: rfsr  in  1  decoded return from subroutine.
REQ-015 Port: done  in  1  decoded done function.
REQ-016 Port: cfg_we, cfg_idx[3:0], cfg_addr[AW-1:0]  in  subroutine-table write port.
REQ-017 Port: pc  out  AW  instruction-memory address.
REQ-018 Port: running, halted, fault  out  1 each  state flags.
REQ-019 Port: depth  out  3  current return-stack occupancy.

Function
REQ-020 States: IDLE, RUN, HALT, FAULT; exactly one flag true in RUN/HALT/FAULT; all flags low in IDLE.
REQ-021 Control inputs (br_nz, jsr, rfsr, done) are acted on only in RUN with stall low; elsewhere they are ignored.
REQ-022 start in any state moves to RUN next cycle: pc<=prog_base, stack emptied, depth<=0; start takes priority over every other input.
REQ-023 RUN priority when several are high: done > rfsr > jsr > br_nz > sequential.
REQ-024 Sequential: pc<=pc+1 modulo 2**AW (1023 wraps to 0).
REQ-025 br_nz: pc<={0,br_target}.
REQ-026 jsr with depth<SDEPTH: push pc+1 (modulo 2**AW), pc<=table[jsr_idx], depth+1.
REQ-027 rfsr with depth>0: pc<=top of stack, pop, depth-1.
REQ-028 jsr with depth==SDEPTH (overflow) or rfsr with depth==0 (underflow): go to FAULT, pc and stack unchanged.
REQ-029 done: go to HALT, pc holds its current value.
REQ-030 HALT and FAULT hold pc and stack until start or reset.
REQ-031 stall high in RUN: pc, stack, depth and state unchanged that cycle.
REQ-032 The subroutine table has 16 entries x AW bits; cfg_we writes cfg_addr into entry cfg_idx at the clock edge, in any state.
REQ-033 A table write and a jsr reading the same entry in the same cycle: jsr uses the pre-write value.
REQ-034 Latency: pc changes exactly one clock after the controlling input is sampled; pc is a registered output with no combinational path from inputs.

Reset
REQ-035 rst_n low asynchronously forces: state IDLE, pc 0, depth 0, stack entries 0, all flags 0.
REQ-036 Reset sets table entry 0 to SUB0_ADDR and entries 1-15 to 0.
REQ-037 Reset asserted mid-subroutine discards the stack; no pending return survives reset.

Verification
REQ-038 Reset release, start with prog_base=0, no controls for 5 cycles -> pc 0,1,2,3,4; running=1.
REQ-039 pc=20, jsr idx 0 -> pc=100, depth=1; later rfsr at pc=112 -> pc=21, depth=0.
REQ-040 pc=84, br_nz with br_target=9 -> pc=9; br_nz with jsr asserted in the same cycle -> jsr wins.
REQ-041 5 nested jsr with SDEPTH=4 -> fault=1 on the 5th, pc frozen; rfsr at depth 0 from a fresh start -> fault=1.
REQ-042 done at pc=86 -> halted=1, pc stays 86; start with prog_base=0 -> running, pc=0.
REQ-043 prog_base=1023, no controls -> pc 1023 then 0; stall held 3 cycles -> pc frozen; rst_n low mid-subroutine -> pc=0, depth=0 immediately.
